sevenseg_scan_ctrl: RTL and testbench

- Time-multiplexes N_DIGITS 4-bit digit values onto one shared 4-bit-to-7-segment decoder and N common-anode/cathode digit enables.
- Sequences digits with a fixed dwell time and a blanking gap to prevent ghosting.
- Loads of new display values are double-buffered and committed only at frame boundaries, so a frame never tears.
- Sits between the value producer (counters, FSMs) and the existing seven-segment decoder plus board display pins.

---
 rtl/sevenseg_pkg.sv | 17 +
 rtl/sevenseg_dwell_timer.sv | 38 +++
 rtl/sevenseg_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    // Map one logical enable bit (1 = digit lit) onto the physical pin level.
    function automatic logic an_level(input logic on, input logic active_low);
        return on ^ active_low;
    endfunction

endpackage

// File: rtl/sevenseg_dwell_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module sevenseg_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic         tc_next
);

    logic [W-1:0] count;
    logic [W-1:0] count_nxt;

    // Next count: reload on request, otherwise count down and hold at zero.
    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (count != '0) begin
            count_nxt = count - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

    assign tc      = (count == '0);
    assign tc_next = (count_nxt == '0);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking gaps and frame-aligned,
// double-buffered display updates.
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int TICKS_PER_DIGIT = 1000,
    parameter int BLANK_TICKS     = 16,
    parameter int AN_ACTIVE_LOW   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            load,
    input  logic [DIGIT_W*N_DIGITS-1:0]     value_in,
    input  logic [N_DIGITS-1:0]             blank_in,
    output logic [DIGIT_W-1:0]              digit_code,
    output logic [N_DIGITS-1:0]             an,
    output logic [$clog2(N_DIGITS)-1:0]     digit_idx,
    output logic                            frame_done
);

    localparam int IW   = $clog2(N_DIGITS);
    localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int VW   = DIGIT_W * N_DIGITS;
    localparam logic AL = (AN_ACTIVE_LOW != 0);
    localparam state_t FIRST_PHASE = (BLANK_TICKS > 0) ? BLANK : SHOW;
    localparam logic [CW-1:0] BLANK_LOAD = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(TICKS_PER_DIGIT - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AL}};

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [VW-1:0]       act_val, act_val_n, sh_val, sh_val_n;
    logic [N_DIGITS-1:0] act_blank, act_blank_n, sh_blank, sh_blank_n;
    logic                pending, pending_n;
    logic                frame_end;
    logic                tmr_load, tc, tc_next;
    logic [CW-1:0]       tmr_val;
    logic [N_DIGITS-1:0] an_n;
    logic [DIGIT_W-1:0]  code_n;
    logic                done_n;

    sevenseg_dwell_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc),
        .tc_next  (tc_next)
    );

    // Scan sequencing: next state, next digit index and the dwell reload.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        frame_end = 1'b0;
        case (state)
            IDLE: begin
                idx_n = '0;
                if (en) state_n = FIRST_PHASE;
            end
            BLANK: begin
                if (tc) state_n = SHOW;
            end
            SHOW: begin
                if (tc) begin
                    state_n = FIRST_PHASE;
                    if (idx == IW'(N_DIGITS - 1)) begin
                        idx_n     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (!en) begin
            state_n   = IDLE;
            idx_n     = '0;
            frame_end = 1'b0;
        end
        // The timer is reloaded on every interval boundary with the length of
        // the interval being entered, so it always times the current state.
        tmr_load = (state == IDLE) || tc || !en;
        if (state_n == BLANK)     tmr_val = BLANK_LOAD;
        else if (state_n == SHOW) tmr_val = SHOW_LOAD;
        else                      tmr_val = '0;
    end

    // Display buffers: direct load while idle, otherwise shadow + commit at frame end.
    always_comb begin
        act_val_n   = act_val;
        act_blank_n = act_blank;
        sh_val_n    = sh_val;
        sh_blank_n  = sh_blank;
        pending_n   = pending;
        if (state == IDLE && load) begin
            act_val_n   = value_in;
            act_blank_n = blank_in;
            sh_val_n    = value_in;
            sh_blank_n  = blank_in;
            pending_n   = 1'b0;
        end else if (frame_end) begin
            if (load) begin
                act_val_n   = value_in;
                act_blank_n = blank_in;
                sh_val_n    = value_in;
                sh_blank_n  = blank_in;
                pending_n   = 1'b0;
            end else if (pending) begin
                act_val_n   = sh_val;
                act_blank_n = sh_blank;
                pending_n   = 1'b0;
            end
        end else if (load) begin
            sh_val_n   = value_in;
            sh_blank_n = blank_in;
            pending_n  = 1'b1;
        end
    end

    // Output values for the next cycle, derived from the next state and buffers
    // so the registered outputs line up with the state they describe.
    always_comb begin
        an_n = AN_OFF;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            an_n[k] = an_level((state_n == SHOW) && (idx_n == IW'(k)) && !act_blank_n[k], AL);
        end
        code_n = '0;
        if (state_n != IDLE) code_n = act_val_n[idx_n*DIGIT_W +: DIGIT_W];
        done_n = (state_n == SHOW) && (idx_n == IW'(N_DIGITS - 1)) && tc_next;
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            act_val    <= '0;
            act_blank  <= '1;
            sh_val     <= '0;
            sh_blank   <= '1;
            pending    <= 1'b0;
            an         <= AN_OFF;
            digit_code <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            act_val    <= act_val_n;
            act_blank  <= act_blank_n;
            sh_val     <= sh_val_n;
            sh_blank   <= sh_blank_n;
            pending    <= pending_n;
            an         <= an_n;
            digit_code <= code_n;
            frame_done <= done_n;
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized self-checking bench for sevenseg_scan_ctrl against a timeline model.
module tb_sevenseg_scan_ctrl;

    localparam int N = 4;
    localparam int T = 4;
    localparam int B = 2;
    localparam int D = B + T;
    localparam int F = N * D;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [15:0] value_in;
    logic [3:0]  blank_in;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model: time since scanning started plus what each frame shows.
    bit          running;
    int          t;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_dblank, m_shblank;
    bit          m_pend;

    sevenseg_scan_ctrl #(
        .N_DIGITS        (N),
        .TICKS_PER_DIGIT (T),
        .BLANK_TICKS     (B),
        .AN_ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .digit_code (digit_code),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    function automatic int cur_p();
        return running ? (t % F) : -1;
    endfunction

    task automatic check_outputs();
        int p, d, w;
        logic [3:0] e_an, e_code;
        logic [1:0] e_idx;
        logic       e_done;
        e_an = 4'hF; e_code = 4'h0; e_idx = 2'd0; e_done = 1'b0;
        if (running) begin
            p = t % F;
            d = p / D;
            w = p % D;
            if (w >= B && !m_dblank[d]) e_an[d] = 1'b0;
            e_code = m_disp[d*4 +: 4];
            e_idx  = 2'(d);
            e_done = (p == F - 1);
        end
        check("an", 32'(an), 32'(e_an));
        check("digit_code", 32'(digit_code), 32'(e_code));
        check("digit_idx", 32'(digit_idx), 32'(e_idx));
        check("frame_done", 32'(frame_done), 32'(e_done));
    endtask

    task automatic model_update(input logic e, input logic l, input logic [15:0] v,
                                input logic [3:0] b, input logic r);
        int p;
        p = running ? (t % F) : 0;
        if (r) begin
            running = 0; t = 0;
            m_disp = '0; m_sh = '0; m_dblank = 4'hF; m_shblank = 4'hF; m_pend = 0;
            return;
        end
        if (!running && l) begin
            m_disp = v; m_sh = v; m_dblank = b; m_shblank = b; m_pend = 0;
        end else if (running && e && p == F - 1) begin
            if (l) begin
                m_disp = v; m_sh = v; m_dblank = b; m_shblank = b; m_pend = 0;
            end else if (m_pend) begin
                m_disp = m_sh; m_dblank = m_shblank; m_pend = 0;
            end
        end else if (l) begin
            m_sh = v; m_shblank = b; m_pend = 1;
        end
        if (!e) begin
            running = 0; t = 0;
        end else if (!running) begin
            running = 1; t = 0;
        end else begin
            t++;
        end
    endtask

    task automatic cycle(input logic e, input logic l, input logic [15:0] v,
                         input logic [3:0] b, input logic r);
        en = e; load = l; value_in = v; blank_in = b; rst = r;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update(e, l, v, b, r);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (cur_p() != p && guard < 2 * F) begin
            run(1);
            guard++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; value_in = '0; blank_in = '0;
        running = 0; t = 0;
        m_disp = '0; m_sh = '0; m_dblank = 4'hF; m_shblank = 4'hF; m_pend = 0;
        @(posedge clk);
        model_update(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
        #1;

        // Reset state, then a direct load while idle and two full frames.
        repeat (2) cycle(1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, 16'h4321, 4'h0, 1'b0);
        run(2 * F + 2);

        // Mid-frame load while digit 1 is lit: must wait for the next frame.
        run_to(D + B + 1);
        cycle(1'b1, 1'b1, 16'h9876, 4'h0, 1'b0);
        run(F + 10);

        // Load coincident with the frame-end cycle commits straight away.
        run_to(F - 1);
        cycle(1'b1, 1'b1, 16'hAAAA, 4'h0, 1'b0);
        run(F + 4);

        // Per-digit blanking mask.
        run_to(F - 1);
        cycle(1'b1, 1'b1, 16'h1234, 4'b0101, 1'b0);
        run(2 * F);

        // Drop enable while digit 2 is lit, then resume.
        run_to(2 * D + B + 1);
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        run(F + 6);

        // Reset in SHOW with an update pending: display goes dark afterwards.
        run_to(B + 1);
        cycle(1'b1, 1'b1, 16'h5555, 4'h0, 1'b0);
        run_to(D + B + 2);
        cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
        run(F + 4);

        // Randomized traffic.
        cycle(1'b0, 1'b1, 16'hC0DE, 4'h0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 99) < 97),
                  1'($urandom_range(0, 9) == 0),
                  16'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                  1'($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
